// File: rtl/load_unit.sv
// RV32I load path: issues a word-aligned read, then extracts and sign/zero-extends the addressed lane.
// Optional build macro MISALIGN_TRAP_EN traps misaligned LH/LHU/LW without touching memory.
module load_unit #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        ld_done,
  output logic [31:0] ld_data,
  output logic        ld_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [7:0]  r_cnt;
  logic        w_accept;
  logic        w_illegal;
  logic        w_misalign;
  logic        w_timeout;

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] o,
                                          input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (o)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = o[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b100:  res = {24'd0, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b101:  res = {16'd0, h};
      default: res = w;
    endcase
    return res;
  endfunction

  assign w_accept  = ld_valid && ld_ready;
  assign w_illegal = !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010 ||
                       funct3 == 3'b100 || funct3 == 3'b101);
`ifdef MISALIGN_TRAP_EN
  assign w_misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3 == 3'b010) && (addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif
  // Timeout fires on the TIMEOUT_CYCLES-th WAIT cycle that sees no read data.
  assign w_timeout = (r_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = (w_illegal || w_misalign) ? S_RESP : S_WAIT;
      S_WAIT: if (mem_rvalid || w_timeout) w_state_nxt = S_RESP;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_ready <= 1'b1;
      mem_req  <= 1'b0;
      mem_addr <= 32'd0;
      ld_done  <= 1'b0;
      ld_data  <= 32'd0;
      ld_err   <= 1'b0;
      r_funct3 <= 3'd0;
      r_off    <= 2'd0;
      r_cnt    <= 8'd0;
    end else begin
      ld_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_funct3 <= funct3;
            r_off    <= addr[1:0];
            r_cnt    <= 8'd0;
            ld_ready <= 1'b0;
            if (w_illegal || w_misalign) begin
              ld_done <= 1'b1;
              ld_err  <= 1'b1;
              ld_data <= 32'd0;
            end else begin
              mem_req  <= 1'b1;
              mem_addr <= {addr[31:2], 2'b00};
            end
          end
        end
        S_WAIT: begin
          // Read data wins over a same-cycle timeout.
          if (mem_rvalid) begin
            mem_req <= 1'b0;
            r_cnt   <= 8'd0;
            ld_done <= 1'b1;
            ld_err  <= 1'b0;
            ld_data <= extract(r_funct3, r_off, mem_rdata);
          end else if (w_timeout) begin
            mem_req <= 1'b0;
            r_cnt   <= 8'd0;
            ld_done <= 1'b1;
            ld_err  <= 1'b1;
            ld_data <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ld_ready <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Directed self-checking bench for load_unit: extraction, latency, illegal funct3, timeout,
// misalignment, async reset abort and back-to-back issue rate.
module tb_load_unit;

  logic        clk;
  logic        rst_n;
  logic        ld_valid;
  logic        ld_ready;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        ld_done;
  logic [31:0] ld_data;
  logic        ld_err;

  int checks = 0;
  int errors = 0;

  load_unit #(.TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .funct3(funct3), .addr(addr), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .ld_done(ld_done),
    .ld_data(ld_data), .ld_err(ld_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed no end required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One load; rv_cycle = WAIT cycle (1-based) carrying mem_rvalid, 0 = never.
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rd, input int rv_cycle, input logic exp_req,
                          input logic [31:0] exp_data, input logic exp_err);
    int n;
    int exp_n;
    n = 0;
    exp_n = (rv_cycle >= 1 && rv_cycle <= 15) ? rv_cycle : 15;
    @(negedge clk);
    ld_valid = 1'b1; funct3 = f3; addr = a;
    @(negedge clk);
    ld_valid = 1'b0;
    chk({tag, "_ready0"}, 32'(ld_ready), 32'd0);
    chk({tag, "_req"}, 32'(mem_req), 32'(exp_req));
    if (exp_req) begin
      chk({tag, "_maddr"}, mem_addr, {a[31:2], 2'b00});
      for (int k = 1; k <= 40; k++) begin
        if (k == rv_cycle) begin
          mem_rvalid = 1'b1; mem_rdata = rd;
        end
        @(negedge clk);
        mem_rvalid = 1'b0;
        if (ld_done) begin
          n = k;
          break;
        end
      end
      chk({tag, "_lat"}, 32'(n), 32'(exp_n));
      chk({tag, "_reqoff"}, 32'(mem_req), 32'd0);
    end
    chk({tag, "_done"}, 32'(ld_done), 32'd1);
    chk({tag, "_data"}, ld_data, exp_data);
    chk({tag, "_err"}, 32'(ld_err), 32'(exp_err));
    @(negedge clk);
    chk({tag, "_done1"}, 32'(ld_done), 32'd0);
    chk({tag, "_ready1"}, 32'(ld_ready), 32'd1);
  endtask

  initial begin
    int dn;
    rst_n = 1'b0; ld_valid = 1'b0; funct3 = 3'd0; addr = 32'd0;
    mem_rvalid = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ld_ready), 32'd1);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_maddr", mem_addr, 32'd0);
    chk("rst_done", 32'(ld_done), 32'd0);
    chk("rst_data", ld_data, 32'd0);
    chk("rst_err", 32'(ld_err), 32'd0);
    rst_n = 1'b1;

    // Lane extraction with immediate read data.
    run_load("lb0",  3'b000, 32'h0000_2000, 32'h8312_F4A5, 1, 1'b1, 32'hFFFF_FFA5, 1'b0);
    run_load("lbu3", 3'b100, 32'h0000_2003, 32'h8312_F4A5, 1, 1'b1, 32'h0000_0083, 1'b0);
    run_load("lh2",  3'b001, 32'h0000_2002, 32'h8312_F4A5, 1, 1'b1, 32'hFFFF_8312, 1'b0);
    run_load("lhu0", 3'b101, 32'h0000_2000, 32'h8312_F4A5, 1, 1'b1, 32'h0000_F4A5, 1'b0);
    run_load("lw0",  3'b010, 32'h0000_2000, 32'h8312_F4A5, 1, 1'b1, 32'h8312_F4A5, 1'b0);
    run_load("lb1",  3'b000, 32'h0000_2001, 32'h8312_F4A5, 1, 1'b1, 32'hFFFF_FFF4, 1'b0);
    run_load("lbu2", 3'b100, 32'h0000_2002, 32'h8312_F4A5, 3, 1'b1, 32'h0000_0012, 1'b0);

    // Illegal funct3.
    run_load("ill", 3'b011, 32'h0000_3000, 32'h0, 0, 1'b0, 32'h0, 1'b1);

    // Timeout, then read data on the last allowed cycle.
    run_load("tmo",  3'b010, 32'h0000_4000, 32'h0, 0, 1'b1, 32'h0, 1'b1);
    run_load("rv15", 3'b010, 32'h0000_4004, 32'h1234_5678, 15, 1'b1, 32'h1234_5678, 1'b0);

    // Misaligned word load.
`ifdef MISALIGN_TRAP_EN
    run_load("mis", 3'b010, 32'h0000_1002, 32'hCAFE_BABE, 1, 1'b0, 32'h0, 1'b1);
`else
    run_load("mis", 3'b010, 32'h0000_1002, 32'hCAFE_BABE, 1, 1'b1, 32'hCAFE_BABE, 1'b0);
`endif

    // Stray read data in IDLE changes nothing.
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("stray_done", 32'(ld_done), 32'd0);
    chk("stray_data", ld_data, 32'hCAFE_BABE);
    chk("stray_ready", 32'(ld_ready), 32'd1);

    // Reset in mid-WAIT aborts at once.
    ld_valid = 1'b1; funct3 = 3'b010; addr = 32'h0000_5000;
    @(negedge clk);
    ld_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_pre_req", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_req", 32'(mem_req), 32'd0);
    chk("abort_done", 32'(ld_done), 32'd0);
    chk("abort_err", 32'(ld_err), 32'd0);
    chk("abort_ready", 32'(ld_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    dn = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (ld_done) dn++;
    end
    chk("abort_nodone", 32'(dn), 32'd0);
    chk("abort_idle_req", 32'(mem_req), 32'd0);

    // ld_valid and mem_rvalid held high: one load every three cycles.
    ld_valid = 1'b1; funct3 = 3'b010; addr = 32'h0000_6000;
    mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_0F0F;
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("b2b_done%0d", k), 32'(ld_done), 32'((k % 3) == 1));
      chk($sformatf("b2b_req%0d", k), 32'(mem_req), 32'((k % 3) == 0));
      if (ld_done) begin
        dn++;
        chk($sformatf("b2b_data%0d", k), ld_data, 32'hA5A5_0F0F);
      end
    end
    chk("b2b_count", 32'(dn), 32'd4);
    ld_valid = 1'b0; mem_rvalid = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
